// File: rtl/pooling_window_buffer_pkg.sv
// Shared definitions for the pooling window buffer: element slice macros and
// the counter-width helper used by the top level and the line buffer.
`ifndef POOLING_WINDOW_BUFFER_MACROS
`define POOLING_WINDOW_BUFFER_MACROS
`define L(w, i) ((((i) + 1) * (w)) - 1)
`define R(w, i) ((i) * (w))
`endif

package pooling_window_buffer_pkg;

   // Never returns less than 1 so a counter with a single state still has a bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/pooling_window_buffer_line.sv
// Holds the first POOL-1 rows of the current pooling band and presents the
// POOL entries ending at the current column of every row as one packed vector.
module pool_line_buffer
   import pooling_window_buffer_pkg::*;
#(
   parameter int D_WIDTH   = 8,
   parameter int POOL      = 2,
   parameter int IMG_WIDTH = 8,
   localparam int ROWS     = POOL - 1,
   localparam int ROW_W    = clog2(POOL),
   localparam int COL_W    = clog2(IMG_WIDTH)
) (
   input  logic                           clk,
   input  logic                           wr_en_i,
   input  logic [ROW_W-1:0]               wr_row_i,
   input  logic [COL_W-1:0]               wr_addr_i,
   input  logic [D_WIDTH-1:0]             wr_data_i,
   input  logic [COL_W-1:0]               rd_base_i,
   output logic [ROWS*POOL*D_WIDTH-1:0]   rd_data_o
);

   logic [D_WIDTH-1:0] mem_q [ROWS][IMG_WIDTH];

   // Contents are never cleared: every entry is rewritten before a window reads it.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int a = 0; a < IMG_WIDTH; a++) begin
               if (wr_row_i == ROW_W'(r) && wr_addr_i == COL_W'(a)) begin
                  mem_q[r][a] <= wr_data_i;
               end
            end
         end
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < POOL; c++) begin : g_col
         localparam int K = r * POOL + c;
         logic [COL_W-1:0]   addr;
         logic [D_WIDTH-1:0] sel;

         assign addr = rd_base_i + COL_W'(c);

         always_comb begin
            sel = '0;
            for (int a = 0; a < IMG_WIDTH; a++) begin
               if (addr == COL_W'(a)) sel = mem_q[r][a];
            end
         end

         assign rd_data_o[`L(D_WIDTH, K):`R(D_WIDTH, K)] = sel;
      end
   end

endmodule

// File: rtl/pooling_window_buffer.sv
// Assembles non-overlapping POOL x POOL windows from a raster pixel stream and
// hands each one to the max-pooling comparator as a single packed word.
module pooling_window_buffer
   import pooling_window_buffer_pkg::*;
#(
   parameter int D_WIDTH    = 8,
   parameter int POOL       = 2,
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [D_WIDTH-1:0]          in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [D_WIDTH*POOL*POOL-1:0] out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last
);

   localparam int ROWS   = POOL - 1;
   localparam int BANDS  = IMG_HEIGHT / POOL;
   localparam int COL_W  = clog2(IMG_WIDTH);
   localparam int ROW_W  = clog2(POOL);
   localparam int BAND_W = clog2(BANDS);
   localparam int WIN_W  = clog2(POOL);
   localparam int OUT_W  = D_WIDTH * POOL * POOL;

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  bandRow_q, bandRow_d;
   logic [BAND_W-1:0] band_q, band_d;
   logic [WIN_W-1:0]  winCol_q, winCol_d;
   logic [POOL-2:0][D_WIDTH-1:0] lastRow_q, lastRow_d;
   logic [OUT_W-1:0]  outData_q, outData_d;
   logic              outValid_q, outValid_d;
   logic              outLast_q, outLast_d;

   logic                         accept;
   logic                         lastRowPhase;
   logic                         winDone;
   logic                         frameEnd;
   logic [ROWS*POOL*D_WIDTH-1:0] lbufData;
   logic [OUT_W-1:0]             window;

   assign in_ready     = !outValid_q || out_ready;
   assign accept       = in_valid && in_ready;
   assign lastRowPhase = (bandRow_q == ROW_W'(POOL - 1));
   assign winDone      = lastRowPhase && (winCol_q == WIN_W'(POOL - 1));
   assign frameEnd     = (col_q == COL_W'(IMG_WIDTH - 1)) && (band_q == BAND_W'(BANDS - 1));

   pool_line_buffer #(
      .D_WIDTH   (D_WIDTH),
      .POOL      (POOL),
      .IMG_WIDTH (IMG_WIDTH)
   ) u_lineBuf (
      .clk       (clk),
      .wr_en_i   (accept && !lastRowPhase),
      .wr_row_i  (bandRow_q),
      .wr_addr_i (col_q),
      .wr_data_i (in_data),
      .rd_base_i (col_q - COL_W'(POOL - 1)),
      .rd_data_o (lbufData)
   );

   // The completing pixel bypasses the shift register straight into the window.
   assign window[ROWS*POOL*D_WIDTH-1:0] = lbufData;
   for (genvar c = 0; c < POOL - 1; c++) begin : g_last
      assign window[`L(D_WIDTH, ROWS*POOL + c):`R(D_WIDTH, ROWS*POOL + c)] = lastRow_q[c];
   end
   assign window[`L(D_WIDTH, POOL*POOL - 1):`R(D_WIDTH, POOL*POOL - 1)] = in_data;

   always_comb begin
      col_d     = col_q;
      bandRow_d = bandRow_q;
      band_d    = band_q;
      winCol_d  = winCol_q;
      if (accept) begin
         winCol_d = (winCol_q == WIN_W'(POOL - 1)) ? '0 : winCol_q + WIN_W'(1);
         if (col_q == COL_W'(IMG_WIDTH - 1)) begin
            col_d = '0;
            if (lastRowPhase) begin
               bandRow_d = '0;
               band_d    = (band_q == BAND_W'(BANDS - 1)) ? '0 : band_q + BAND_W'(1);
            end else begin
               bandRow_d = bandRow_q + ROW_W'(1);
            end
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_comb begin
      lastRow_d = lastRow_q;
      if (accept && lastRowPhase) begin
         for (int i = 0; i < POOL - 2; i++) lastRow_d[i] = lastRow_q[i+1];
         lastRow_d[POOL-2] = in_data;
      end
   end

   // A window loaded on the same edge that consumes the old one keeps out_valid high.
   always_comb begin
      outData_d  = outData_q;
      outValid_d = outValid_q;
      outLast_d  = outLast_q;
      if (accept && winDone) begin
         outData_d  = window;
         outValid_d = 1'b1;
         outLast_d  = frameEnd;
      end else if (outValid_q && out_ready) begin
         outValid_d = 1'b0;
         outLast_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q      <= '0;
         bandRow_q  <= '0;
         band_q     <= '0;
         winCol_q   <= '0;
         lastRow_q  <= '0;
         outData_q  <= '0;
         outValid_q <= 1'b0;
         outLast_q  <= 1'b0;
      end else begin
         col_q      <= col_d;
         bandRow_q  <= bandRow_d;
         band_q     <= band_d;
         winCol_q   <= winCol_d;
         lastRow_q  <= lastRow_d;
         outData_q  <= outData_d;
         outValid_q <= outValid_d;
         outLast_q  <= outLast_d;
      end
   end

   assign out_data  = outData_q;
   assign out_valid = outValid_q;
   assign out_last  = outLast_q;

endmodule

// File: tb/tb_pooling_window_buffer.sv
// Directed bench for pooling_window_buffer: a 4x4 POOL=2 instance driven from
// a vector table and hand sequences, plus a 6x3 POOL=3 instance.
module tb_pooling_window_buffer;

   typedef struct {
      logic [7:0]  pix;
      logic        expValid;
      logic [31:0] expData;
      logic        expLast;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [7:0]  inDataA = '0;
   logic        inValidA = 1'b0;
   logic        inReadyA;
   logic [31:0] outDataA;
   logic        outValidA;
   logic        outReadyA = 1'b0;
   logic        outLastA;

   logic [7:0]  inDataB = '0;
   logic        inValidB = 1'b0;
   logic        inReadyB;
   logic [71:0] outDataB;
   logic        outValidB;
   logic        outReadyB = 1'b0;
   logic        outLastB;

   int vecCount = 0;
   int missCount = 0;

   logic [31:0] gotDataA[$];
   logic        gotLastA[$];
   logic [71:0] gotDataB[$];
   logic        gotLastB[$];

   logic [31:0] expWin[4];
   logic [7:0]  expMax[4];
   vec_t        tbl[16];

   always #5 clk = ~clk;

   pooling_window_buffer #(
      .D_WIDTH(8), .POOL(2), .IMG_WIDTH(4), .IMG_HEIGHT(4)
   ) dutA (
      .clk(clk), .rst_n(rst_n),
      .in_data(inDataA), .in_valid(inValidA), .in_ready(inReadyA),
      .out_data(outDataA), .out_valid(outValidA), .out_ready(outReadyA),
      .out_last(outLastA)
   );

   pooling_window_buffer #(
      .D_WIDTH(8), .POOL(3), .IMG_WIDTH(6), .IMG_HEIGHT(3)
   ) dutB (
      .clk(clk), .rst_n(rst_n),
      .in_data(inDataB), .in_valid(inValidB), .in_ready(inReadyB),
      .out_data(outDataB), .out_valid(outValidB), .out_ready(outReadyB),
      .out_last(outLastB)
   );

   // Record every window handshake, sampled mid-low-phase before the consuming edge.
   always begin
      @(negedge clk);
      #1;
      if (rst_n && outValidA && outReadyA) begin
         gotDataA.push_back(outDataA);
         gotLastA.push_back(outLastA);
      end
      if (rst_n && outValidB && outReadyB) begin
         gotDataB.push_back(outDataB);
         gotLastB.push_back(outLastB);
      end
   end

   task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst_n    = 1'b0;
      inValidA = 1'b0;
      inValidB = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      gotDataA.delete();
      gotLastA.delete();
      gotDataB.delete();
      gotLastB.delete();
   endtask

   // Offer one pixel to dutA and return on the negedge after it is accepted.
   task automatic applyStimulus(input logic [7:0] p);
      int  waitCycles;
      logic took;
      waitCycles = 0;
      took       = 1'b0;
      inDataA    = p;
      inValidA   = 1'b1;
      while (!took && waitCycles < 200) begin
         #1;
         took = inReadyA;
         @(negedge clk);
         waitCycles++;
      end
      if (!took) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL handshake timeout: pixel %0d not accepted, in_ready %0b, expected 1", p, inReadyA);
      end
      inValidA = 1'b0;
   endtask

   task automatic checkWindowsA(input string tag, input int expCount);
      int lastSeen;
      lastSeen = 0;
      checkOutput({tag, " window count"}, 72'(gotDataA.size()), 72'(expCount));
      for (int i = 0; i < gotDataA.size() && i < expCount; i++) begin
         checkOutput($sformatf("%s win%0d data", tag, i), 72'(gotDataA[i]), 72'(expWin[i % 4]));
         checkOutput($sformatf("%s win%0d last", tag, i), 72'(gotLastA[i]), 72'((i % 4) == 3));
         if (gotLastA[i]) lastSeen++;
      end
      checkOutput({tag, " last count"}, 72'(lastSeen), 72'(expCount / 4));
   endtask

   function automatic logic [7:0] maxOf4(input logic [31:0] w);
      logic [7:0] m;
      m = w[7:0];
      for (int k = 1; k < 4; k++) begin
         if (w[k*8 +: 8] > m) m = w[k*8 +: 8];
      end
      return m;
   endfunction

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic              readyTimedOut;
      logic              streamDone;
      logic [71:0]       expB0;
      logic [71:0]       expB1;

      expWin[0] = 32'h05040100;
      expWin[1] = 32'h07060302;
      expWin[2] = 32'h0d0c0908;
      expWin[3] = 32'h0f0e0b0a;
      expMax[0] = 8'd5;
      expMax[1] = 8'd7;
      expMax[2] = 8'd13;
      expMax[3] = 8'd15;
      for (int i = 0; i < 16; i++) tbl[i] = '{8'(i), 1'b0, 32'h0, 1'b0};
      tbl[5]  = '{8'd5,  1'b1, 32'h05040100, 1'b0};
      tbl[7]  = '{8'd7,  1'b1, 32'h07060302, 1'b0};
      tbl[13] = '{8'd13, 1'b1, 32'h0d0c0908, 1'b0};
      tbl[15] = '{8'd15, 1'b1, 32'h0f0e0b0a, 1'b1};
      expB0 = {8'd14, 8'd13, 8'd12, 8'd8, 8'd7, 8'd6, 8'd2, 8'd1, 8'd0};
      expB1 = {8'd17, 8'd16, 8'd15, 8'd11, 8'd10, 8'd9, 8'd5, 8'd4, 8'd3};
      readyTimedOut = 1'b0;

      $display("[TB] reset state");
      outReadyA = 1'b0;
      applyReset();
      checkOutput("reset out_valid", 72'(outValidA), 72'(0));
      checkOutput("reset out_last",  72'(outLastA),  72'(0));
      checkOutput("reset out_data",  72'(outDataA),  72'(0));
      checkOutput("reset in_ready",  72'(inReadyA),  72'(1));

      $display("[TB] streaming frame, one pixel per cycle");
      outReadyA = 1'b1;
      for (int i = 0; i < 16; i++) begin
         inValidA = 1'b1;
         inDataA  = tbl[i].pix;
         @(negedge clk);
         checkOutput($sformatf("stream px%0d out_valid", i), 72'(outValidA), 72'(tbl[i].expValid));
         checkOutput($sformatf("stream px%0d out_last", i),  72'(outLastA),  72'(tbl[i].expLast));
         if (tbl[i].expValid)
            checkOutput($sformatf("stream px%0d out_data", i), 72'(outDataA), 72'(tbl[i].expData));
      end
      inValidA = 1'b0;
      repeat (3) @(negedge clk);
      checkWindowsA("stream", 4);
      for (int i = 0; i < gotDataA.size() && i < 4; i++)
         checkOutput($sformatf("pooled max %0d", i), 72'(maxOf4(gotDataA[i])), 72'(expMax[i]));

      $display("[TB] downstream stall after first window");
      outReadyA = 1'b0;
      applyReset();
      for (int p = 0; p < 6; p++) applyStimulus(8'(p));
      checkOutput("stall out_valid", 72'(outValidA), 72'(1));
      checkOutput("stall in_ready",  72'(inReadyA),  72'(0));
      checkOutput("stall out_data",  72'(outDataA),  72'(32'h05040100));
      inDataA  = 8'd6;
      inValidA = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("held out_data",  72'(outDataA),  72'(32'h05040100));
      checkOutput("held in_ready",  72'(inReadyA),  72'(0));
      checkOutput("held out_valid", 72'(outValidA), 72'(1));
      outReadyA = 1'b1;
      for (int p = 6; p < 16; p++) applyStimulus(8'(p));
      repeat (3) @(negedge clk);
      checkWindowsA("stall", 4);

      $display("[TB] random gaps and backpressure over two frames");
      outReadyA = 1'b0;
      applyReset();
      streamDone = 1'b0;
      fork
         begin
            for (int f = 0; f < 2; f++) begin
               for (int p = 0; p < 16; p++) begin
                  repeat ($urandom_range(0, 2)) @(negedge clk);
                  applyStimulus(8'(p));
               end
            end
            streamDone = 1'b1;
         end
         begin
            while (!streamDone) begin
               outReadyA = 1'($urandom_range(1));
               @(negedge clk);
            end
         end
      join
      outReadyA = 1'b1;
      repeat (4) @(negedge clk);
      checkWindowsA("random", 8);

      $display("[TB] reset while a window is pending");
      applyReset();
      outReadyA = 1'b1;
      for (int p = 0; p < 5; p++) applyStimulus(8'(p));
      outReadyA = 1'b0;
      applyStimulus(8'd5);
      inDataA  = 8'd6;
      inValidA = 1'b1;
      rst_n    = 1'b0;
      #1;
      checkOutput("midreset out_valid", 72'(outValidA), 72'(0));
      checkOutput("midreset in_ready",  72'(inReadyA),  72'(1));
      checkOutput("midreset out_data",  72'(outDataA),  72'(0));
      checkOutput("midreset out_last",  72'(outLastA),  72'(0));
      inValidA = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      gotDataA.delete();
      gotLastA.delete();
      outReadyA = 1'b1;
      for (int p = 0; p < 16; p++) applyStimulus(8'(p));
      repeat (3) @(negedge clk);
      checkWindowsA("after reset", 4);

      $display("[TB] POOL=3 instance");
      outReadyB = 1'b1;
      applyReset();
      for (int p = 0; p < 18; p++) begin
         inValidB = 1'b1;
         inDataB  = 8'(p);
         @(negedge clk);
         if (!inReadyB) readyTimedOut = 1'b1;
      end
      inValidB = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("pool3 in_ready held", 72'(readyTimedOut), 72'(0));
      checkOutput("pool3 window count", 72'(gotDataB.size()), 72'(2));
      if (gotDataB.size() >= 2) begin
         checkOutput("pool3 win0 data", gotDataB[0], expB0);
         checkOutput("pool3 win0 last", 72'(gotLastB[0]), 72'(0));
         checkOutput("pool3 win1 data", gotDataB[1], expB1);
         checkOutput("pool3 win1 last", 72'(gotLastB[1]), 72'(1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
